// File: rtl/serial_adder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_adder_if                                                     |
// | Operand and result valid/ready handshakes for serial_adder.         |
// | The master modport drives operands and consumes results; the slave  |
// | modport is the adder's view.                                        |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_adder                                                        |
// | Bit-serial adder: one full-adder bit per clock, LSB first, through  |
// | a single carry flip-flop. Returns sum, carry-out and signed         |
// | overflow after WIDTH RUN cycles.                                    |
// | Optional feature macro: SERIAL_ADDER_SUB_EN (enables a - b).        |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic             cout_r;
  logic             ovf_r;
  logic [CNT_W-1:0] cnt;

  logic             in_ready_d;
  logic             out_valid_d;
  logic             take;
  logic             last_bit;
  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  assign take     = (state == IDLE) && bus.in_valid;
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // One full-adder slice over the current LSBs and the stored carry.
  assign bit_s = a_sr[0] ^ b_sr[0] ^ carry;
  assign bit_c = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

`ifdef SERIAL_ADDER_SUB_EN
  // Subtract as a + ~b + 1; cin is ignored in that case.
  assign b_load = bus.sub ? ~bus.b : bus.b;
  assign c_load = bus.sub ? 1'b1   : bus.cin;
`else
  // Add only: sub is present on the port but has no effect.
  logic unused_sub;
  assign unused_sub = bus.sub;
  assign b_load     = bus.b;
  assign c_load     = bus.cin;
`endif

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and handshake decodes (pure functions of state).
  always_comb begin
    state_next  = state;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    case (state)
      IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid_d = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture, serial datapath and result latching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      cnt    <= '0;
    end else if (take) begin
      a_sr  <= bus.a;
      b_sr  <= b_load;
      carry <= c_load;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      carry  <= bit_c;
      sum_sr <= {bit_s, sum_sr[WIDTH-1:1]};
      cnt    <= cnt + CNT_W'(1);
      if (last_bit) begin
        // Carry into the MSB is the stored carry; carry out is the new one.
        cout_r <= bit_c;
        ovf_r  <= carry ^ bit_c;
      end
    end
  end

  assign bus.in_ready  = in_ready_d;
  assign bus.out_valid = out_valid_d;
  assign bus.sum       = sum_sr;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_serial_adder                                                     |
// | Self-checking bench for serial_adder (WIDTH=8): directed cases,     |
// | random operations against an arithmetic model, back-to-back flow,   |
// | backpressure and asynchronous reset abort.                          |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_serial_adder;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  serial_adder_if #(.WIDTH(W)) bus_i ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} from plain arithmetic on the operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic ci, input logic sb);
    logic [W-1:0] bb;
    logic         cc;
    logic [W:0]   full;
    logic         ov;
    bb = bv;
    cc = ci;
`ifdef SERIAL_ADDER_SUB_EN
    if (sb) begin
      bb = ~bv;
      cc = 1'b1;
    end
`else
    if (sb) begin
      bb = bv;
    end
`endif
    full = {1'b0, av} + {1'b0, bb} + {{W{1'b0}}, cc};
    ov   = (av[W-1] == bb[W-1]) && (full[W-1] != av[W-1]);
    return {ov, full};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation with latency, in_ready, backpressure and transfer checks.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                        input logic sb, input int hold, input logic [W+1:0] exp,
                        input string tag);
    int lat;
    bit ready_seen;
    check({tag, "_in_ready_idle"}, {71'd0, bus_i.in_ready}, 72'd1);
    bus_i.in_valid = 1'b1;
    bus_i.a        = av;
    bus_i.b        = bv;
    bus_i.cin      = ci;
    bus_i.sub      = sb;
    tick();
    // Operands are free to change after the handshake.
    bus_i.in_valid = 1'b0;
    bus_i.a        = W'($urandom);
    bus_i.b        = W'($urandom);
    bus_i.cin      = 1'($urandom);
    bus_i.sub      = 1'($urandom);
    lat        = 0;
    ready_seen = 1'b0;
    while (!bus_i.out_valid && lat < 4 * W) begin
      if (bus_i.in_ready) ready_seen = 1'b1;
      bus_i.in_valid = 1'($urandom);
      tick();
      lat++;
    end
    bus_i.in_valid = 1'b0;
    check({tag, "_latency"}, 72'(lat), 72'(W));
    check({tag, "_in_ready_run"}, {71'd0, ready_seen}, 72'd0);
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold"}, {{(71-W-3){1'b0}}, bus_i.in_ready, bus_i.out_valid,
             bus_i.ovf, bus_i.cout, bus_i.sum}, {{(71-W-3){1'b0}}, 1'b0, 1'b1, exp});
      tick();
    end
    check({tag, "_sum"},  72'(bus_i.sum),  72'(exp[W-1:0]));
    check({tag, "_cout"}, 72'(bus_i.cout), 72'(exp[W]));
    check({tag, "_ovf"},  72'(bus_i.ovf),  72'(exp[W+1]));
    bus_i.out_ready = 1'b1;
    tick();
    bus_i.out_ready = 1'b0;
    check({tag, "_after_xfer"}, {70'd0, bus_i.in_ready, bus_i.out_valid}, 72'b10);
  endtask

  initial begin
    logic [W+1:0] q[$];
    logic [W+1:0] e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;
    int           last_t;

    errors = 0;
    checks = 0;
    rst_n           = 1'b0;
    bus_i.in_valid  = 1'b0;
    bus_i.a         = '0;
    bus_i.b         = '0;
    bus_i.cin       = 1'b0;
    bus_i.sub       = 1'b0;
    bus_i.out_ready = 1'b0;

    #12;
    check("rst_values", {{(71-W-3){1'b0}}, bus_i.in_ready, bus_i.out_valid,
           bus_i.ovf, bus_i.cout, bus_i.sum}, {{(71-W-3){1'b0}}, 1'b1, {(W+3){1'b0}}});
    tick();
    rst_n = 1'b1;
    tick();

    // Directed cases.
    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 0, {1'b0, 1'b0, 8'h10}, "add_0f_01");
    run_op(8'hFF, 8'h00, 1'b1, 1'b0, 0, {1'b0, 1'b1, 8'h00}, "add_ff_00_c");
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 5, {1'b1, 1'b0, 8'h80}, "add_7f_01_bp");
`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 1'b1, 1'b1, 0, {1'b0, 1'b0, 8'hFE}, "sub_05_07");
    run_op(8'h80, 8'h01, 1'b0, 1'b1, 0, {1'b1, 1'b1, 8'h7F}, "sub_80_01");
`else
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 0, {1'b0, 1'b0, 8'h0C}, "nosub_05_07");
`endif

    // Random operations against the arithmetic model.
    for (int n = 0; n < 12; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      run_op(ra, rb, rc, rs, int'($urandom_range(0, 3)), model(ra, rb, rc, rs), "rand");
    end

    // Back-to-back: in_valid and out_ready held high.
    bus_i.in_valid  = 1'b1;
    bus_i.out_ready = 1'b1;
    last_t = -1;
    for (int cyc = 0; cyc < 45; cyc++) begin
      if (bus_i.out_valid) begin
        e = (q.size() > 0) ? q.pop_front() : '1;
        check("b2b_result", 72'(bus_i.out_valid ? {bus_i.ovf, bus_i.cout, bus_i.sum} : '0), 72'(e));
        if (last_t >= 0) check("b2b_period", 72'(cyc - last_t), 72'(W + 2));
        last_t = cyc;
      end
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      bus_i.a   = ra;
      bus_i.b   = rb;
      bus_i.cin = rc;
      bus_i.sub = rs;
      if (bus_i.in_ready) q.push_back(model(ra, rb, rc, rs));
      tick();
    end
    bus_i.in_valid = 1'b0;
    for (int i = 0; i < 4 * W && q.size() > 0; i++) begin
      if (bus_i.out_valid) begin
        e = q.pop_front();
        check("b2b_drain", 72'({bus_i.ovf, bus_i.cout, bus_i.sum}), 72'(e));
      end
      tick();
    end
    check("b2b_queue_empty", 72'(q.size()), 72'd0);
    bus_i.out_ready = 1'b0;
    for (int i = 0; i < 4 * W && !bus_i.in_ready; i++) tick();

    // Asynchronous reset abort during RUN cycle 3.
    bus_i.in_valid = 1'b1;
    bus_i.a        = 8'hFF;
    bus_i.b        = 8'h00;
    bus_i.cin      = 1'b0;
    bus_i.sub      = 1'b0;
    tick();
    bus_i.in_valid = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_abort", {{(71-W-3){1'b0}}, bus_i.in_ready, bus_i.out_valid,
           bus_i.ovf, bus_i.cout, bus_i.sum}, {{(71-W-3){1'b0}}, 1'b1, {(W+3){1'b0}}});
    #2;
    rst_n = 1'b1;
    tick();
    run_op(8'h01, 8'h01, 1'b0, 1'b0, 0, {1'b0, 1'b0, 8'h02}, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
